// File: rtl/axi4_lite_copy_master.sv
// AXI4-Lite initiator that copies len words from src_addr to dst_addr,
// one single-beat read followed by one single-beat write per word.
module axi4_lite_copy_master #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   src_addr,
   input  logic [ADDR_WIDTH-1:0]   dst_addr,
   input  logic [LEN_WIDTH-1:0]    len,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [ADDR_WIDTH-1:0]   AWADDR,
   output logic                    AWVALID,
   input  logic                    AWREADY,
   output logic [DATA_WIDTH-1:0]   WDATA,
   output logic [DATA_WIDTH/8-1:0] WSTRB,
   output logic                    WVALID,
   input  logic                    WREADY,
   input  logic [1:0]              BRESP,
   input  logic                    BVALID,
   output logic                    BREADY,
   output logic [ADDR_WIDTH-1:0]   ARADDR,
   output logic                    ARVALID,
   input  logic                    ARREADY,
   input  logic [DATA_WIDTH-1:0]   RDATA,
   input  logic [1:0]              RRESP,
   input  logic                    RVALID,
   output logic                    RREADY
);

   localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(DATA_WIDTH / 8);

   typedef enum logic [2:0] {
      S_IDLE,
      S_AR,
      S_R,
      S_W,
      S_B,
      S_DONE
   } state_t;

   state_t                  r_state, w_state_next;
   logic [ADDR_WIDTH-1:0]   r_src, w_src_next;
   logic [ADDR_WIDTH-1:0]   r_dst, w_dst_next;
   logic [LEN_WIDTH-1:0]    r_remaining, w_remaining_next;
   logic                    r_busy, w_busy_next;
   logic                    r_err, w_err_next;
   logic [ADDR_WIDTH-1:0]   r_araddr, w_araddr_next;
   logic                    r_arvalid, w_arvalid_next;
   logic                    r_rready, w_rready_next;
   logic [ADDR_WIDTH-1:0]   r_awaddr, w_awaddr_next;
   logic                    r_awvalid, w_awvalid_next;
   logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_next;
   logic                    r_wvalid, w_wvalid_next;
   logic                    r_bready, w_bready_next;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_src_next       = r_src;
      w_dst_next       = r_dst;
      w_remaining_next = r_remaining;
      w_busy_next      = r_busy;
      w_err_next       = r_err;
      w_araddr_next    = r_araddr;
      w_arvalid_next   = r_arvalid;
      w_rready_next    = r_rready;
      w_awaddr_next    = r_awaddr;
      w_awvalid_next   = r_awvalid;
      w_wdata_next     = r_wdata;
      w_wvalid_next    = r_wvalid;
      w_bready_next    = r_bready;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_err_next       = 1'b0;
               w_src_next       = src_addr;
               w_dst_next       = dst_addr;
               w_remaining_next = len;
               if (len != '0) begin
                  w_araddr_next  = src_addr;
                  w_arvalid_next = 1'b1;
                  w_busy_next    = 1'b1;
                  w_state_next   = S_AR;
               end else begin
                  w_state_next   = S_DONE;
               end
            end
         end
         S_AR: begin
            if (r_arvalid && ARREADY) begin
               w_arvalid_next = 1'b0;
               w_rready_next  = 1'b1;
               w_state_next   = S_R;
            end
         end
         S_R: begin
            if (RVALID && r_rready) begin
               w_rready_next = 1'b0;
               if (RRESP != 2'b00) begin
                  w_err_next   = 1'b1;
                  w_state_next = S_DONE;
               end else begin
                  w_awaddr_next  = r_dst;
                  w_wdata_next   = RDATA;
                  w_awvalid_next = 1'b1;
                  w_wvalid_next  = 1'b1;
                  w_state_next   = S_W;
               end
            end
         end
         S_W: begin
            // A cleared VALID marks its handshake as done; wait until both are clear.
            w_awvalid_next = r_awvalid && !AWREADY;
            w_wvalid_next  = r_wvalid && !WREADY;
            if (!w_awvalid_next && !w_wvalid_next) begin
               w_bready_next = 1'b1;
               w_state_next  = S_B;
            end
         end
         S_B: begin
            if (BVALID && r_bready) begin
               w_bready_next = 1'b0;
               if (BRESP != 2'b00) begin
                  w_err_next   = 1'b1;
                  w_state_next = S_DONE;
               end else begin
                  w_remaining_next = r_remaining - LEN_WIDTH'(1);
                  if (r_remaining == LEN_WIDTH'(1)) begin
                     w_state_next = S_DONE;
                  end else begin
                     w_src_next     = r_src + STRIDE;
                     w_dst_next     = r_dst + STRIDE;
                     w_araddr_next  = r_src + STRIDE;
                     w_arvalid_next = 1'b1;
                     w_state_next   = S_AR;
                  end
               end
            end
         end
         S_DONE: begin
            w_busy_next  = 1'b0;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_src       <= '0;
         r_dst       <= '0;
         r_remaining <= '0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
         r_araddr    <= '0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_awaddr    <= '0;
         r_awvalid   <= 1'b0;
         r_wdata     <= '0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
      end else begin
         r_src       <= w_src_next;
         r_dst       <= w_dst_next;
         r_remaining <= w_remaining_next;
         r_busy      <= w_busy_next;
         r_err       <= w_err_next;
         r_araddr    <= w_araddr_next;
         r_arvalid   <= w_arvalid_next;
         r_rready    <= w_rready_next;
         r_awaddr    <= w_awaddr_next;
         r_awvalid   <= w_awvalid_next;
         r_wdata     <= w_wdata_next;
         r_wvalid    <= w_wvalid_next;
         r_bready    <= w_bready_next;
      end
   end

   assign busy    = r_busy;
   assign done    = (r_state == S_DONE);
   assign err     = r_err;
   assign ARADDR  = r_araddr;
   assign ARVALID = r_arvalid;
   assign RREADY  = r_rready;
   assign AWADDR  = r_awaddr;
   assign AWVALID = r_awvalid;
   assign WDATA   = r_wdata;
   assign WSTRB   = '1;
   assign WVALID  = r_wvalid;
   assign BREADY  = r_bready;

endmodule

// File: tb/tb_axi4_lite_copy_master.sv
// Directed bench for axi4_lite_copy_master against a small AXI4-Lite RAM slave model
// with programmable AW/W stalls and an injectable read error.
`timescale 1ns/1ps
module tb_axi4_lite_copy_master;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  src_addr = '0;
   logic [9:0]  dst_addr = '0;
   logic [7:0]  len = '0;
   logic        busy, done, err;
   logic [9:0]  AWADDR, ARADDR;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RVALID, RREADY;
   logic [31:0] WDATA, RDATA;
   logic [3:0]  WSTRB;
   logic [1:0]  BRESP, RRESP;

   int total = 0;
   int bad   = 0;

   always #5 ACLK = ~ACLK;

   axi4_lite_copy_master #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LEN_WIDTH(8)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .src_addr(src_addr),
      .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .err(err),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
   );

   // ---------------- slave model ----------------
   logic [31:0] mem [0:255];
   int          aw_stall = 0, w_stall = 0, err_word = 99;
   int          aw_cnt, w_cnt, rd_cnt;
   logic        aw_got, w_got;
   logic [9:0]  s_waddr;
   logic [31:0] s_wdata;
   logic        pl_en = 1'b0;
   logic [7:0]  pl_idx = '0;
   logic [31:0] pl_data = '0;

   assign ARREADY = 1'b1;
   assign AWREADY = (aw_cnt >= aw_stall);
   assign WREADY  = (w_cnt >= w_stall);
   assign BRESP   = 2'b00;

   logic        w_aw_hs, w_w_hs, w_commit;
   logic [9:0]  w_commit_addr;
   logic [31:0] w_commit_data;
   assign w_aw_hs       = AWVALID && AWREADY;
   assign w_w_hs        = WVALID && WREADY;
   assign w_commit      = !(aw_got && w_got) && (aw_got || w_aw_hs) && (w_got || w_w_hs);
   assign w_commit_addr = w_aw_hs ? AWADDR : s_waddr;
   assign w_commit_data = w_w_hs ? WDATA : s_wdata;

   always @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         RVALID <= 1'b0; RDATA <= '0; RRESP <= 2'b00; BVALID <= 1'b0;
         aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0; rd_cnt <= 0;
         s_waddr <= '0; s_wdata <= '0;
      end else begin
         if (start) rd_cnt <= 0;
         if (ARVALID && ARREADY) begin
            RVALID <= 1'b1;
            RDATA  <= mem[ARADDR[9:2]];
            RRESP  <= (rd_cnt == err_word) ? 2'b10 : 2'b00;
            rd_cnt <= rd_cnt + 1;
         end else if (RVALID && RREADY) begin
            RVALID <= 1'b0;
         end
         if (w_aw_hs) begin aw_cnt <= 0; aw_got <= 1'b1; s_waddr <= AWADDR; end
         else if (AWVALID) aw_cnt <= aw_cnt + 1;
         if (w_w_hs) begin w_cnt <= 0; w_got <= 1'b1; s_wdata <= WDATA; end
         else if (WVALID) w_cnt <= w_cnt + 1;
         if (w_commit) BVALID <= 1'b1;
         else if (BVALID && BREADY) begin BVALID <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; end
      end
   end

   always @(posedge ACLK) begin
      if (pl_en) mem[pl_idx] <= pl_data;
      else if (ARESETN && w_commit) mem[w_commit_addr[9:2]] <= w_commit_data;
   end

   // ---------------- protocol monitors ----------------
   int          stab_viol = 0, bready_early = 0, arv_cnt = 0, awv_cnt = 0, ar_n = 0;
   logic [9:0]  ar_log [0:15];
   logic        p_arv, p_arhs, p_awv, p_awhs, p_wv, p_whs;
   logic [9:0]  p_araddr, p_awaddr;
   logic [31:0] p_wdata;

   always @(posedge ACLK) begin
      if (!ARESETN) begin
         p_arv <= 1'b0; p_awv <= 1'b0; p_wv <= 1'b0;
         p_arhs <= 1'b0; p_awhs <= 1'b0; p_whs <= 1'b0;
      end else begin
         if (p_arv && !p_arhs && (!ARVALID || ARADDR !== p_araddr)) stab_viol <= stab_viol + 1;
         if (p_awv && !p_awhs && (!AWVALID || AWADDR !== p_awaddr)) stab_viol <= stab_viol + 1;
         if (p_wv && !p_whs && (!WVALID || WDATA !== p_wdata)) stab_viol <= stab_viol + 1;
         if (BREADY && !(aw_got && w_got)) bready_early <= bready_early + 1;
         if (ARVALID) arv_cnt <= arv_cnt + 1;
         if (AWVALID) awv_cnt <= awv_cnt + 1;
         p_arv <= ARVALID; p_arhs <= ARVALID && ARREADY; p_araddr <= ARADDR;
         p_awv <= AWVALID; p_awhs <= w_aw_hs; p_awaddr <= AWADDR;
         p_wv <= WVALID; p_whs <= w_w_hs; p_wdata <= WDATA;
      end
      if (start) ar_n <= 0;
      else if (ARVALID && ARREADY && ar_n < 16) begin
         ar_log[ar_n] <= ARADDR;
         ar_n <= ar_n + 1;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic poke(input int idx, input logic [31:0] data);
      @(negedge ACLK);
      pl_en = 1'b1; pl_idx = idx[7:0]; pl_data = data;
      @(negedge ACLK);
      pl_en = 1'b0;
   endtask

   task automatic run_copy(input logic [9:0] s, input logic [9:0] d, input logic [7:0] n,
                           output int cyc, output logic busy0, output logic err0,
                           output logic done_next, output logic busy_next);
      @(negedge ACLK);
      src_addr = s; dst_addr = d; len = n; start = 1'b1;
      @(negedge ACLK);
      start = 1'b0;
      src_addr = 10'h155; dst_addr = 10'h2AA; len = 8'hFF;
      busy0 = busy; err0 = err; cyc = 0;
      while (!done && cyc < 300) begin
         @(negedge ACLK);
         cyc++;
      end
      @(negedge ACLK);
      done_next = done; busy_next = busy;
      $display("copy src=%03h dst=%03h len=%0d -> done after %0d cycles err=%0b", s, d, n, cyc, err);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) @(negedge ACLK);
      ARESETN = 1'b1;
      @(negedge ACLK);
      total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL reset_status got=%b want=000", {busy, done, err}); end
      total++; if ({ARVALID, RREADY, AWVALID, WVALID, BREADY} !== 5'b0) begin bad++; $display("FAIL reset_handshake got=%b want=00000", {ARVALID, RREADY, AWVALID, WVALID, BREADY}); end
      total++; if ({AWADDR, ARADDR} !== 20'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", {AWADDR, ARADDR}); end
      total++; if (WDATA !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", WDATA); end
      total++; if (WSTRB !== 4'hF) begin bad++; $display("FAIL reset_wstrb got=%h want=f", WSTRB); end
   endtask

   task automatic test_copy4();
      int cyc; logic b0, e0, dn, bn;
      poke(0, 32'h11); poke(1, 32'h22); poke(2, 32'h33); poke(3, 32'h44);
      run_copy(10'h000, 10'h100, 8'd4, cyc, b0, e0, dn, bn);
      total++; if (cyc !== 16) begin bad++; $display("FAIL copy4_latency got=%0d want=16", cyc); end
      total++; if (b0 !== 1'b1) begin bad++; $display("FAIL copy4_busy_start got=%b want=1", b0); end
      total++; if ({dn, bn} !== 2'b00) begin bad++; $display("FAIL copy4_after_done got=%b want=00", {dn, bn}); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL copy4_err got=%b want=0", err); end
      for (int i = 0; i < 4; i++) begin
         total++; if (mem[64+i] !== 32'h11 * (i + 1)) begin bad++; $display("FAIL copy4_data[%0d] got=%h want=%h", i, mem[64+i], 32'h11 * (i + 1)); end
      end
   endtask

   task automatic test_len_zero();
      int cyc, arv0, awv0; logic b0, e0, dn, bn;
      arv0 = arv_cnt; awv0 = awv_cnt;
      run_copy(10'h010, 10'h110, 8'd0, cyc, b0, e0, dn, bn);
      total++; if (cyc !== 0) begin bad++; $display("FAIL len0_latency got=%0d want=0", cyc); end
      total++; if ({b0, bn, dn} !== 3'b000) begin bad++; $display("FAIL len0_busy got=%b want=000", {b0, bn, dn}); end
      total++; if (arv_cnt !== arv0 || awv_cnt !== awv0) begin bad++; $display("FAIL len0_traffic got=%0d/%0d want=%0d/%0d", arv_cnt, awv_cnt, arv0, awv0); end
   endtask

   task automatic test_wrap();
      int cyc; logic b0, e0, dn, bn;
      poke(255, 32'hA5A50001);
      run_copy(10'h3FC, 10'h200, 8'd2, cyc, b0, e0, dn, bn);
      total++; if (cyc !== 8) begin bad++; $display("FAIL wrap_latency got=%0d want=8", cyc); end
      total++; if (ar_n !== 2 || ar_log[0] !== 10'h3FC || ar_log[1] !== 10'h000) begin bad++; $display("FAIL wrap_araddr got=%0d:%h,%h want=2:3fc,000", ar_n, ar_log[0], ar_log[1]); end
      total++; if (mem[128] !== 32'hA5A50001) begin bad++; $display("FAIL wrap_word0 got=%h want=a5a50001", mem[128]); end
      total++; if (mem[129] !== 32'h11) begin bad++; $display("FAIL wrap_word1 got=%h want=00000011", mem[129]); end
   endtask

   task automatic test_read_error();
      int cyc; logic b0, e0, dn, bn;
      for (int i = 0; i < 4; i++) begin
         poke(16 + i, 32'hC0DE0000 + i);
         poke(80 + i, 32'hDEAD0000 + i);
      end
      err_word = 1;
      run_copy(10'h040, 10'h140, 8'd4, cyc, b0, e0, dn, bn);
      err_word = 99;
      total++; if (cyc !== 6) begin bad++; $display("FAIL rerr_latency got=%0d want=6", cyc); end
      total++; if (err !== 1'b1 || e0 !== 1'b0) begin bad++; $display("FAIL rerr_err got=%b/%b want=1/0", err, e0); end
      total++; if ({dn, bn} !== 2'b00) begin bad++; $display("FAIL rerr_after_done got=%b want=00", {dn, bn}); end
      total++; if (mem[80] !== 32'hC0DE0000 || mem[81] !== 32'hDEAD0001) begin bad++; $display("FAIL rerr_written got=%h,%h want=c0de0000,dead0001", mem[80], mem[81]); end
      run_copy(10'h044, 10'h148, 8'd1, cyc, b0, e0, dn, bn);
      total++; if (e0 !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rerr_clear got=%b/%b want=0/0", e0, err); end
      total++; if (mem[82] !== 32'hC0DE0001) begin bad++; $display("FAIL rerr_next_copy got=%h want=c0de0001", mem[82]); end
   endtask

   task automatic test_back_to_back_stalls();
      int cyc, sv0, be0; logic b0, e0, dn, bn;
      poke(32, 32'h5A5A0000); poke(33, 32'h5A5A0001);
      sv0 = stab_viol; be0 = bready_early;
      aw_stall = 3; w_stall = 0;
      run_copy(10'h080, 10'h180, 8'd2, cyc, b0, e0, dn, bn);
      total++; if (cyc !== 14) begin bad++; $display("FAIL awstall_latency got=%0d want=14", cyc); end
      total++; if (mem[96] !== 32'h5A5A0000 || mem[97] !== 32'h5A5A0001) begin bad++; $display("FAIL awstall_data got=%h,%h want=5a5a0000,5a5a0001", mem[96], mem[97]); end
      aw_stall = 0; w_stall = 3;
      run_copy(10'h080, 10'h1C0, 8'd2, cyc, b0, e0, dn, bn);
      w_stall = 0;
      total++; if (cyc !== 14) begin bad++; $display("FAIL wstall_latency got=%0d want=14", cyc); end
      total++; if (mem[112] !== 32'h5A5A0000 || mem[113] !== 32'h5A5A0001) begin bad++; $display("FAIL wstall_data got=%h,%h want=5a5a0000,5a5a0001", mem[112], mem[113]); end
      total++; if (stab_viol !== sv0) begin bad++; $display("FAIL stall_payload_stable got=%0d want=%0d", stab_viol, sv0); end
      total++; if (bready_early !== be0) begin bad++; $display("FAIL stall_bready_early got=%0d want=%0d", bready_early, be0); end
   endtask

   task automatic test_reset_mid_write();
      int cyc; logic b0, e0, dn, bn;
      poke(8, 32'h66660008); poke(192, 32'hBEEF0000); poke(193, 32'hBEEF0001);
      aw_stall = 100;
      @(negedge ACLK);
      src_addr = 10'h020; dst_addr = 10'h300; len = 8'd1; start = 1'b1;
      @(negedge ACLK);
      start = 1'b0;
      repeat (3) @(negedge ACLK);
      total++; if ({AWVALID, WVALID, busy} !== 3'b101) begin bad++; $display("FAIL midw_state got=%b want=101", {AWVALID, WVALID, busy}); end
      #2 ARESETN = 1'b0;
      #1;
      total++; if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, busy, done} !== 7'b0) begin bad++; $display("FAIL midw_async_reset got=%b want=0000000", {AWVALID, WVALID, BREADY, ARVALID, RREADY, busy, done}); end
      repeat (2) @(negedge ACLK);
      aw_stall = 0;
      ARESETN = 1'b1;
      run_copy(10'h020, 10'h304, 8'd1, cyc, b0, e0, dn, bn);
      total++; if (cyc !== 4) begin bad++; $display("FAIL midw_recover_latency got=%0d want=4", cyc); end
      total++; if (mem[193] !== 32'h66660008 || mem[192] !== 32'hBEEF0000) begin bad++; $display("FAIL midw_recover_data got=%h,%h want=66660008,beef0000", mem[193], mem[192]); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL midw_recover_err got=%b want=0", err); end
   endtask

   initial begin
      test_reset();
      test_copy4();
      test_len_zero();
      test_wrap();
      test_read_error();
      test_back_to_back_stalls();
      test_reset_mid_write();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
